cond_logic: RTL and testbench

//  Condition unit sitting directly downstream of the multicycle control decoder.

---
 rtl/cond_logic_if.sv | 23 ++
 rtl/cond_logic.sv | 52 +++++
 tb/tb_cond_logic.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder-to-condition-unit strobes and the gated datapath enables.
interface cond_logic_if;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       CondEx;
   logic [3:0] Flags;
   modport master (
      output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      input  PCWrite, RegWrite, MemWrite, CondEx, Flags
   );
   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      output PCWrite, RegWrite, MemWrite, CondEx, Flags
   );
endinterface

// File: rtl/cond_logic.sv
// cond_logic: holds NZCV, evaluates the condition field and gates the decoder write strobes.
module cond_logic #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input logic        clk,
   input logic        reset,
   cond_logic_if.slave bus
);
   logic [3:0] flags;
   logic       cond_ex;
   logic       cond_ex_d;
   logic [1:0] flag_write;
   logic       n, z, c, v;
   assign {n, z, c, v} = flags;
   always_comb begin
      cond_ex = 1'b1;
      case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~(c & ~z);
         4'b1010: cond_ex = n ~^ v;
         4'b1011: cond_ex = n ^ v;
         4'b1100: cond_ex = ~z & (n ~^ v);
         4'b1101: cond_ex = ~(~z & (n ~^ v));
         default: cond_ex = 1'b1;
      endcase
   end
   // a failed condition blocks its own flag update
   assign flag_write = bus.FlagW & {2{cond_ex}};
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         flags     <= RESET_FLAGS;
         cond_ex_d <= 1'b0;
      end else begin
         if (flag_write[1]) flags[3:2] <= bus.ALUFlags[3:2];
         if (flag_write[0]) flags[1:0] <= bus.ALUFlags[1:0];
         cond_ex_d <= cond_ex;
      end
   // strobes are forced low for the whole reset pulse, not just from the next edge
   assign bus.PCWrite  = reset & ((bus.PCS & cond_ex_d) | bus.NextPC);
   assign bus.RegWrite = reset & bus.RegW & cond_ex_d;
   assign bus.MemWrite = reset & bus.MemW & cond_ex_d;
   assign bus.CondEx   = cond_ex;
   assign bus.Flags    = flags;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: corner-vector table, full cond/flags sweep and randomized run against a rule-based model.
module tb_cond_logic;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   cond_logic_if bus ();
   cond_logic dut (.clk(clk), .reset(reset), .bus(bus));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end");
      $fatal(1, "watchdog");
   end
   typedef struct {
      logic [3:0] cond;
      logic [3:0] flags;
      logic       exp;
   } vec_t;
   function automatic logic ref_cond(input logic [3:0] cd, input logic [3:0] f);
      logic nf, zf, cf, vf, base;
      nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
      case (cd[3:1])
         3'd0: base = zf;
         3'd1: base = cf;
         3'd2: base = nf;
         3'd3: base = vf;
         3'd4: base = cf && !zf;
         3'd5: base = (nf == vf);
         3'd6: base = !zf && (nf == vf);
         default: base = 1'b1;
      endcase
      return (cd == 4'hF) ? 1'b1 : (base ^ cd[0]);
   endfunction
   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask
   task automatic idle();
      bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.NextPC = 1'b0;
      bus.RegW = 1'b0; bus.MemW = 1'b0; bus.ALUFlags = 4'h0;
   endtask
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_flags(input logic [3:0] f);
      bus.Cond = 4'hE; bus.FlagW = 2'b11; bus.ALUFlags = f;
      edge_step();
      bus.FlagW = 2'b00;
   endtask
   vec_t vecs[$];
   logic [3:0] m_flags;
   logic       m_cd, ce;
   initial begin
      vecs = '{
         '{4'hA, 4'b1000, 1'b0}, '{4'hA, 4'b1001, 1'b1}, '{4'hB, 4'b1000, 1'b1},
         '{4'hB, 4'b0000, 1'b0}, '{4'hC, 4'b0100, 1'b0}, '{4'hC, 4'b0000, 1'b1},
         '{4'hC, 4'b1000, 1'b0}, '{4'hD, 4'b0100, 1'b1}, '{4'hD, 4'b0000, 1'b0},
         '{4'h8, 4'b0110, 1'b0}, '{4'h8, 4'b0010, 1'b1}, '{4'h9, 4'b0110, 1'b1},
         '{4'h9, 4'b0010, 1'b0}, '{4'hF, 4'b0000, 1'b1}, '{4'hE, 4'b0000, 1'b1},
         '{4'h0, 4'b0100, 1'b1}, '{4'h1, 4'b0100, 1'b0}, '{4'h6, 4'b0001, 1'b1},
         '{4'h7, 4'b0001, 1'b0}, '{4'h4, 4'b1000, 1'b1}, '{4'h5, 4'b1000, 1'b0},
         '{4'h2, 4'b0010, 1'b1}, '{4'h3, 4'b0010, 1'b0}
      };
      // reset with every request raised
      reset = 1'b0; bus.Cond = 4'hE; idle();
      bus.RegW = 1'b1; bus.MemW = 1'b1; bus.NextPC = 1'b1; bus.PCS = 1'b1;
      edge_step();
      chk("rst_pcwrite", {3'b0, bus.PCWrite}, 4'h0);
      chk("rst_regwrite", {3'b0, bus.RegWrite}, 4'h0);
      chk("rst_memwrite", {3'b0, bus.MemWrite}, 4'h0);
      chk("rst_flags", bus.Flags, 4'h0);
      reset = 1'b1; bus.PCS = 1'b0; bus.MemW = 1'b0;
      #1;
      chk("post_rst_pcwrite", {3'b0, bus.PCWrite}, 4'h1);
      chk("post_rst_regwrite", {3'b0, bus.RegWrite}, 4'h0);
      idle();
      // flag write, then half write
      set_flags(4'b0100);
      chk("fw_flags", bus.Flags, 4'b0100);
      bus.Cond = 4'h0; #1;
      chk("fw_eq", {3'b0, bus.CondEx}, 4'h1);
      bus.Cond = 4'hE; bus.FlagW = 2'b10; bus.ALUFlags = 4'b1011;
      edge_step();
      bus.FlagW = 2'b00;
      chk("fw_half", bus.Flags, 4'b1000);
      // one-cycle delay of the condition
      set_flags(4'b0100);
      bus.Cond = 4'h1; bus.RegW = 1'b1; #1;
      chk("dly_ne", {3'b0, bus.CondEx}, 4'h0);
      edge_step();
      chk("dly_regw_off", {3'b0, bus.RegWrite}, 4'h0);
      bus.Cond = 4'h0; #1;
      chk("dly_condex_up", {3'b0, bus.CondEx}, 4'h1);
      chk("dly_regw_still_off", {3'b0, bus.RegWrite}, 4'h0);
      edge_step();
      chk("dly_regw_on", {3'b0, bus.RegWrite}, 4'h1);
      idle();
      // failed condition suppresses flags and strobes
      set_flags(4'b0000);
      bus.Cond = 4'h0; bus.FlagW = 2'b11; bus.ALUFlags = 4'hF; #1;
      chk("sup_condex", {3'b0, bus.CondEx}, 4'h0);
      edge_step();
      chk("sup_flags", bus.Flags, 4'h0);
      bus.FlagW = 2'b00; bus.MemW = 1'b1; bus.PCS = 1'b1; #1;
      chk("sup_memwrite", {3'b0, bus.MemWrite}, 4'h0);
      chk("sup_pcwrite", {3'b0, bus.PCWrite}, 4'h0);
      idle();
      // corner vectors
      foreach (vecs[i]) begin
         set_flags(vecs[i].flags);
         bus.Cond = vecs[i].cond; #1;
         chk($sformatf("vec%0d_c%h_f%b", i, vecs[i].cond, vecs[i].flags), {3'b0, bus.CondEx}, {3'b0, vecs[i].exp});
      end
      // full sweep against the model
      for (int f = 0; f < 16; f++) begin
         set_flags(4'(f));
         for (int cd = 0; cd < 16; cd++) begin
            bus.Cond = 4'(cd); #1;
            chk($sformatf("sweep_c%h_f%h", cd, f), {3'b0, bus.CondEx}, {3'b0, ref_cond(4'(cd), 4'(f))});
         end
      end
      // randomized traffic against the model
      set_flags(4'b0110);
      m_flags = 4'b0110; m_cd = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.Cond = 4'($urandom); bus.ALUFlags = 4'($urandom); bus.FlagW = 2'($urandom);
         bus.PCS = 1'($urandom); bus.NextPC = 1'($urandom_range(0, 3) == 0);
         bus.RegW = 1'($urandom); bus.MemW = 1'($urandom);
         #1;
         ce = ref_cond(bus.Cond, m_flags);
         chk("rnd_condex", {3'b0, bus.CondEx}, {3'b0, ce});
         chk("rnd_flags", bus.Flags, m_flags);
         chk("rnd_pcwrite", {3'b0, bus.PCWrite}, {3'b0, (bus.PCS & m_cd) | bus.NextPC});
         chk("rnd_regwrite", {3'b0, bus.RegWrite}, {3'b0, bus.RegW & m_cd});
         chk("rnd_memwrite", {3'b0, bus.MemWrite}, {3'b0, bus.MemW & m_cd});
         if (ce && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
         if (ce && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
         m_cd = ce;
         edge_step();
      end
      idle();
      // async reset in the middle of a writeback cycle
      set_flags(4'b1010);
      bus.Cond = 4'hE; bus.RegW = 1'b1;
      edge_step();
      chk("ar_regwrite_before", {3'b0, bus.RegWrite}, 4'h1);
      #2 reset = 1'b0;
      #1;
      chk("ar_regwrite_drop", {3'b0, bus.RegWrite}, 4'h0);
      chk("ar_flags", bus.Flags, 4'h0);
      reset = 1'b1;
      #1;
      chk("ar_regwrite_release", {3'b0, bus.RegWrite}, 4'h0);
      edge_step();
      chk("ar_regwrite_next", {3'b0, bus.RegWrite}, 4'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
